// File: rtl/uart_bus_bridge.sv
// rtl/uart_bus_bridge.sv - RS-232 host to PLP data bus initiator (8N1 rx/tx, command parser, bus sequencer)
//
// Ports:
//   clk     system clock, all logic on posedge
//   rst     asynchronous active-low reset
//   rxd     serial in from host (asynchronous, idle high)
//   txd     serial out to host (idle high, registered)
//   de      data bus enable, one clock per access
//   drw     1 = write, 0 = read
//   daddr   word-aligned bus address (holds last value)
//   dwdata  write data (holds last value)
//   drdata  read data from selected responder
//   busy    high whenever the command FSM is not idle
//
// Optional feature macro: UART_BRIDGE_AUTOINC_EN adds command 0x4E 'N'
// (write to last word address + 4).

module uart_bus_bridge #(
    parameter int CLK_RATE       = 25000000,
    parameter int BAUD           = 57600,
    parameter int TIMEOUT_CYCLES = 2500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    output logic        txd,
    output logic        de,
    output logic        drw,
    output logic [31:0] daddr,
    output logic [31:0] dwdata,
    input  logic [31:0] drdata,
    output logic        busy
);

    localparam int DIV  = CLK_RATE / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV + 1);
    localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);

    // ---------------------------------------------------------------
    // Receiver
    // ---------------------------------------------------------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t      rx_state;
    logic           rx_meta;
    logic           rx_sync;
    logic [CW-1:0]  rx_cnt;
    logic [2:0]     rx_bits;
    logic [7:0]     rx_shift;
    logic           rx_valid;
    logic [7:0]     rx_byte;

    // Synchronizer presets to the idle level so reset release is not a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bits  <= '0;
            rx_shift <= '0;
            rx_valid <= 1'b0;
            rx_byte  <= '0;
        end else begin
            rx_valid <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    if (!rx_sync) rx_state <= RX_START;
                end
                RX_START: begin
                    // Re-check the line mid start bit; a high level means a glitch.
                    if (rx_cnt == CW'(HALF - 1)) begin
                        rx_cnt   <= '0;
                        rx_bits  <= '0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == CW'(DIV - 1)) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        rx_bits  <= rx_bits + 3'd1;
                        if (rx_bits == 3'd7) rx_state <= RX_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == CW'(DIV - 1)) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_sync) begin
                            rx_valid <= 1'b1;
                            rx_byte  <= rx_shift;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Transmitter
    // ---------------------------------------------------------------
    logic           tx_busy;
    logic [8:0]     tx_shift;
    logic [3:0]     tx_bitn;
    logic [CW-1:0]  tx_cnt;
    logic           tx_start;
    logic [7:0]     tx_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            txd      <= 1'b1;
            tx_busy  <= 1'b0;
            tx_shift <= '0;
            tx_bitn  <= '0;
            tx_cnt   <= '0;
        end else if (!tx_busy) begin
            tx_cnt  <= '0;
            tx_bitn <= '0;
            if (tx_start) begin
                tx_busy  <= 1'b1;
                txd      <= 1'b0;
                tx_shift <= {1'b1, tx_data};
            end
        end else if (tx_cnt == CW'(DIV - 1)) begin
            tx_cnt <= '0;
            // Bit 9 is the stop bit; once it has lasted DIV clocks we are idle.
            if (tx_bitn == 4'd9) begin
                tx_busy <= 1'b0;
            end else begin
                txd      <= tx_shift[0];
                tx_shift <= {1'b1, tx_shift[8:1]};
                tx_bitn  <= tx_bitn + 4'd1;
            end
        end else begin
            tx_cnt <= tx_cnt + 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // Command FSM and bus sequencer
    // ---------------------------------------------------------------
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP} state_t;

    state_t         state;
    logic           cmd_write;
    logic [1:0]     byte_n;
    logic [31:0]    addr_sh;
    logic [31:0]    data_sh;
    logic [31:0]    resp_sh;
    logic [2:0]     resp_left;
    logic [TW-1:0]  tmo;
    logic [31:0]    bus_addr;

`ifdef UART_BRIDGE_AUTOINC_EN
    logic           cmd_inc;
    // daddr still holds the last word address used, so it doubles as the
    // auto-increment base; 32-bit wrap takes 0xFFFFFFFC to 0.
    assign bus_addr = cmd_inc ? (daddr + 32'd4) : {addr_sh[31:2], 2'b00};
`else
    assign bus_addr = {addr_sh[31:2], 2'b00};
`endif

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cmd_write <= 1'b0;
            byte_n    <= '0;
            addr_sh   <= '0;
            data_sh   <= '0;
            resp_sh   <= '0;
            resp_left <= '0;
            tmo       <= '0;
            tx_start  <= 1'b0;
            tx_data   <= '0;
            de        <= 1'b0;
            drw       <= 1'b0;
            daddr     <= '0;
            dwdata    <= '0;
`ifdef UART_BRIDGE_AUTOINC_EN
            cmd_inc   <= 1'b0;
`endif
        end else begin
            tx_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    tmo    <= '0;
                    byte_n <= '0;
                    if (rx_valid) begin
`ifdef UART_BRIDGE_AUTOINC_EN
                        cmd_inc <= 1'b0;
`endif
                        case (rx_byte)
                            8'h57: begin
                                cmd_write <= 1'b1;
                                state     <= S_ADDR;
                            end
                            8'h52: begin
                                cmd_write <= 1'b0;
                                state     <= S_ADDR;
                            end
`ifdef UART_BRIDGE_AUTOINC_EN
                            8'h4E: begin
                                cmd_write <= 1'b1;
                                cmd_inc   <= 1'b1;
                                state     <= S_DATA;
                            end
`endif
                            default: begin
                                resp_sh   <= {8'h15, 24'h0};
                                resp_left <= 3'd1;
                                state     <= S_RESP;
                            end
                        endcase
                    end
                end
                S_ADDR: begin
                    if (rx_valid) begin
                        tmo     <= '0;
                        addr_sh <= {addr_sh[23:0], rx_byte};
                        byte_n  <= byte_n + 2'd1;
                        if (byte_n == 2'd3) begin
                            if (cmd_write) begin
                                state <= S_DATA;
                            end else begin
                                state <= S_BUS;
                                de    <= 1'b1;
                                drw   <= 1'b0;
                                daddr <= {addr_sh[23:0], rx_byte[7:2], 2'b00};
                            end
                        end
                    end else if (tmo == TW'(TIMEOUT_CYCLES)) begin
                        state <= S_IDLE;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                S_DATA: begin
                    if (rx_valid) begin
                        tmo     <= '0;
                        data_sh <= {data_sh[23:0], rx_byte};
                        byte_n  <= byte_n + 2'd1;
                        if (byte_n == 2'd3) begin
                            state  <= S_BUS;
                            de     <= 1'b1;
                            drw    <= 1'b1;
                            daddr  <= bus_addr;
                            dwdata <= {data_sh[23:0], rx_byte};
                        end
                    end else if (tmo == TW'(TIMEOUT_CYCLES)) begin
                        state <= S_IDLE;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                S_BUS: begin
                    // de was raised on entry; this edge ends the access and
                    // captures the responder's read data.
                    de    <= 1'b0;
                    state <= S_RESP;
                    if (cmd_write) begin
                        resp_sh   <= {8'h06, 24'h0};
                        resp_left <= 3'd1;
                    end else begin
                        resp_sh   <= drdata;
                        resp_left <= 3'd4;
                    end
                end
                S_RESP: begin
                    // tx_busy lags tx_start by a clock, so wait out the pulse
                    // before deciding whether the transmitter is free.
                    if (!tx_start && !tx_busy) begin
                        if (resp_left != 3'd0) begin
                            tx_start  <= 1'b1;
                            tx_data   <= resp_sh[31:24];
                            resp_sh   <= {resp_sh[23:0], 8'h00};
                            resp_left <= resp_left - 3'd1;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// tb/tb_uart_bus_bridge.sv - scoreboard bench for uart_bus_bridge (bus-cycle and reply-byte queues)

module tb_uart_bus_bridge;

    localparam int DIV = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rxd = 1'b1;
    logic        txd;
    logic        de;
    logic        drw;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [31:0] drdata = 32'h0;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [64:0] bus_q[$];
    logic [7:0]  tx_q[$];

    always #5 clk = ~clk;

    uart_bus_bridge #(
        .CLK_RATE(1600),
        .BAUD(100),
        .TIMEOUT_CYCLES(2000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rxd(rxd),
        .txd(txd),
        .de(de),
        .drw(drw),
        .daddr(daddr),
        .dwdata(dwdata),
        .drdata(drdata),
        .busy(busy)
    );

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Bus monitor: every de cycle is popped against the expected access.
    logic de_prev = 1'b0;
    always @(negedge clk) begin
        if (de) begin
            check("de_single_cycle", 72'(de_prev), 72'(0));
            if (bus_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL bus_unexpected: got drw=%0b daddr=%0h dwdata=%0h required no access",
                         drw, daddr, dwdata);
            end else begin
                check("bus_cycle", 72'({drw, daddr, dwdata}), 72'(bus_q.pop_front()));
            end
        end
        de_prev = de;
    end

    // Serial monitor: decode txd frames mid-bit and pop expected reply bytes.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (rst && txd == 1'b0) begin
                repeat (DIV / 2) @(negedge clk);
                check("tx_start_bit", 72'(txd), 72'(0));
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge clk);
                    b[i] = txd;
                end
                repeat (DIV) @(negedge clk);
                check("tx_stop_bit", 72'(txd), 72'(1));
                check("busy_during_reply", 72'(busy), 72'(1));
                if (tx_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL tx_unexpected: got byte %0h required none", b);
                end else begin
                    check("tx_byte", 72'(b), 72'(tx_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b, input bit stop_ok = 1'b1);
        @(negedge clk);
        rxd = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (DIV) @(negedge clk);
        end
        rxd = stop_ok;
        repeat (DIV) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (busy && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_busy_drop"}, 72'(busy), 72'(0));
        check({name, "_tx_queue_empty"}, 72'(tx_q.size()), 72'(0));
        check({name, "_bus_queue_empty"}, 72'(bus_q.size()), 72'(0));
        check({name, "_txd_idle"}, 72'(txd), 72'(1));
        repeat (DIV) @(negedge clk);
    endtask

    initial begin
        int bad;
        logic [7:0] cmd_w[9];
        logic [7:0] cmd_r[5];
        logic [7:0] cmd_r2[5];
        logic [7:0] cmd_r4[5];
        logic [7:0] cmd_wf[9];
        cmd_w  = '{8'h57, 8'h00, 8'h00, 8'h10, 8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        cmd_r  = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h08};
        cmd_r2 = '{8'h52, 8'h12, 8'h34, 8'h56, 8'h7F};
        cmd_r4 = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h04};
        cmd_wf = '{8'h57, 8'hFF, 8'hFF, 8'hFF, 8'hFC, 8'hCA, 8'hFE, 8'hF0, 8'h0D};

        // Reset held with rxd toggling.
        bad = 0;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            rxd = i[2];
            if (txd !== 1'b1 || de !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("reset_txd_de_busy", 72'(bad), 72'(0));
        check("reset_bus_regs", 72'({drw, daddr, dwdata}), 72'(0));
        rxd = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        repeat (300) @(negedge clk);
        check("post_reset_busy", 72'(busy), 72'(0));

        // Write word.
        bus_q.push_back({1'b1, 32'h0000_1000, 32'hDEAD_BEEF});
        tx_q.push_back(8'h06);
        foreach (cmd_w[i]) send_byte(cmd_w[i]);
        wait_done("write");

        // Read word.
        drdata = 32'h1234_5678;
        bus_q.push_back({1'b0, 32'h0000_0008, 32'hDEAD_BEEF});
        tx_q.push_back(8'h12); tx_q.push_back(8'h34); tx_q.push_back(8'h56); tx_q.push_back(8'h78);
        foreach (cmd_r[i]) send_byte(cmd_r[i]);
        wait_done("read");

        // Read with low address bits set: they must be forced to zero.
        drdata = 32'hA5C3_0F81;
        bus_q.push_back({1'b0, 32'h1234_567C, 32'hDEAD_BEEF});
        tx_q.push_back(8'hA5); tx_q.push_back(8'hC3); tx_q.push_back(8'h0F); tx_q.push_back(8'h81);
        foreach (cmd_r2[i]) send_byte(cmd_r2[i]);
        wait_done("read_unaligned");
        check("hold_daddr", 72'(daddr), 72'(32'h1234_567C));
        check("hold_dwdata", 72'(dwdata), 72'(32'hDEAD_BEEF));
        check("hold_drw", 72'(drw), 72'(0));

        // Unknown command.
        tx_q.push_back(8'h15);
        send_byte(8'h41);
        wait_done("nak");

        // 8-clock low glitch.
        @(negedge clk);
        rxd = 1'b0;
        repeat (8) @(negedge clk);
        rxd = 1'b1;
        repeat (200) @(negedge clk);
        check("glitch_busy", 72'(busy), 72'(0));

        // Framing error: stop bit low.
        send_byte(8'h41, 1'b0);
        repeat (300) @(negedge clk);
        check("stop0_busy", 72'(busy), 72'(0));

        // Inter-byte timeout mid frame.
        send_byte(8'h57);
        send_byte(8'h00);
        send_byte(8'h00);
        check("timeout_busy_before", 72'(busy), 72'(1));
        repeat (2050) @(negedge clk);
        check("timeout_busy_after", 72'(busy), 72'(0));

        drdata = 32'h1234_5678;
        bus_q.push_back({1'b0, 32'h0000_0004, 32'hDEAD_BEEF});
        tx_q.push_back(8'h12); tx_q.push_back(8'h34); tx_q.push_back(8'h56); tx_q.push_back(8'h78);
        foreach (cmd_r4[i]) send_byte(cmd_r4[i]);
        wait_done("read_after_timeout");

        // Write at the top word, then the 'N' command.
        bus_q.push_back({1'b1, 32'hFFFF_FFFC, 32'hCAFE_F00D});
        tx_q.push_back(8'h06);
        foreach (cmd_wf[i]) send_byte(cmd_wf[i]);
        wait_done("write_top");

`ifdef UART_BRIDGE_AUTOINC_EN
        bus_q.push_back({1'b1, 32'h0000_0000, 32'h0000_0001});
        tx_q.push_back(8'h06);
        send_byte(8'h4E);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h01);
        wait_done("autoinc");
`else
        tx_q.push_back(8'h15);
        send_byte(8'h4E);
        wait_done("autoinc_nak");
`endif

        repeat (100) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_bus_bridge.md
Name: uart_bus_bridge

Overview:
- Serial-to-bus initiator: an RS-232 host reads and writes words on the PLP data bus through this block, for memory loading and debug peek/poke.
- It is the master end of the memory-mapped interface that peripherals such as the UART respond to.
- Contains its own 8N1 receiver and transmitter, a command parser and a single-cycle bus-access sequencer.

Parameters:
- CLK_RATE, 25000000, clock frequency in Hz.
- BAUD, 57600, serial bit rate. DIV = CLK_RATE/BAUD clocks per bit, integer-truncated.
- TIMEOUT_CYCLES, 2500000, maximum idle clocks between bytes inside a frame.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- rxd  in  1  serial in from host; asynchronous, idle high.
- txd  out  1  serial out to host; idle high.
- de  out  1  data bus enable.
- drw  out  1  1 = write, 0 = read.
- daddr  out  32  bus address.
- dwdata  out  32  write data, wired to responders' din.
- drdata  in  32  read data from the selected responder's dout.
- busy  out  1  high whenever the command FSM is not IDLE.

Behaviour:
- Reset values: txd=1, de=0, drw=0, daddr=0, dwdata=0, busy=0. All FSMs go to idle and all counters clear. The rxd synchronizer flops preset to 1.
- Reset mid-frame aborts everything immediately. No partial bus access is issued and no response is sent.
- Receiver:
  - rxd passes through a 2-flop synchronizer.
  - In idle, a sampled 0 starts a frame. Wait DIV/2 clocks and re-sample; if rxd is 1, treat it as a false start and return to idle.
  - Then take 8 data samples, LSB first, each DIV clocks apart, then the stop sample DIV clocks later.
  - Stop = 1: raise an internal rx_valid pulse for 1 clock with the byte. Stop = 0: discard the byte.
  - The receiver returns to idle at the stop sample.
- Transmitter:
  - Accepts a byte only when idle.
  - Sends start 0, 8 data bits LSB first, then stop 1; each bit lasts exactly DIV clocks; txd is registered.
  - tx_idle returns after the stop bit completes.
- Command protocol (host to bridge), addresses and data MSB-first:
  - 0x57 'W', A3 A2 A1 A0, D3 D2 D1 D0: write word; bridge replies 0x06.
  - 0x52 'R', A3 A2 A1 A0: read word; bridge replies D3 D2 D1 D0.
  - Any other first byte: reply 0x15 (NAK), back to IDLE.
- Command FSM states: IDLE, ADDR, DATA, BUS, RESP.
  - IDLE: on rx_valid, decode the command as above.
  - ADDR: collect 4 bytes into the address.
  - DATA: write only; collect 4 bytes.
  - BUS: lasts exactly one clock.
  - RESP: queue the reply bytes to the transmitter, then return to IDLE once the last stop bit completes.
- Bus cycle:
  - In BUS, de=1 for exactly one clock, with daddr = {addr[31:2],2'b00}; the low 2 address bits are forced to 0.
  - Write: drw=1 and dwdata = data. Responders commit on the mid-cycle negedge.
  - Read: drw=0, and drdata is captured on the posedge ending the BUS cycle.
  - de returns to 0 the next clock. daddr, dwdata and drw hold their last values.
- Bytes received while in BUS or RESP are dropped.
- Timeout: a counter clears on every rx_valid and counts in ADDR and DATA. When it reaches TIMEOUT_CYCLES, the FSM returns to IDLE with no bus access and no reply.

Optional Feature:
- UART_BRIDGE_AUTOINC_EN defined: adds command 0x4E 'N' followed by D3..D0.
  - It writes to the last used word address + 4, wrapping 0xFFFFFFFC to 0x00000000, and replies 0x06.
  - The address register is updated, so consecutive 'N' commands stream words.
  - The address register resets to 0, so an 'N' issued with no prior command writes to 0x00000004.
- Not defined: 0x4E is an unknown command and is NAKed; no extra logic is present.

Test Plan (CLK_RATE=1600, BAUD=100, DIV=16, TIMEOUT_CYCLES=2000):
- Reset: hold rst=0 with rxd toggling -> txd=1, de=0, busy=0 throughout; after release, no bytes on txd.
- Write: send 57 00 00 10 03 DE AD BE EF -> exactly one clock with de=1, drw=1, daddr=0x00001000, dwdata=0xDEADBEEF; then txd frame 0x06.
- Read: drdata=0x12345678 while sending 52 00 00 00 08 -> one de=1/drw=0 cycle at daddr=0x00000008; txd sends 12 34 56 78; busy drops after the last stop bit.
- Errors:
  - Send 0x41 -> txd 0x15 with no de activity.
  - Inject an 8-clock low glitch on rxd -> no byte received.
  - Send a byte with stop=0 -> the byte is ignored.
- Timeout: send 57 00 00, then idle 2000 clocks -> FSM returns to IDLE with no de pulse and no reply. A following 52 00 00 00 04 then executes normally.
- Autoinc (macro on): send W to 0xFFFFFFFC, then 4E 00 00 00 01 -> second write at daddr=0x00000000, reply 0x06. With the macro off, the 0x4E byte is NAKed with 0x15.
